// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake and operand/result bundle for the
// iterative divider. The requester uses the master modport; the divider uses
// the slave modport.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: radix-2 unsigned restoring divider, one quotient bit per clock.
// A start accepted in IDLE or DONE takes WIDTH RUN cycles, then presents
// quotient/remainder/div_by_zero with a one-cycle done pulse. Results are held
// until the next accepted start. Reset is synchronous and active-low.
// Optional build macro SEQ_DIV_ZERO_FAST_EN: a start with divisor == 0 skips
// RUN and goes straight to DONE (same result values, busy never rises).
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;

    // Working registers: partial remainder, shifting dividend/quotient, divisor.
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] divisor_q;

    // One restoring step, computed from the working registers.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    logic accept;
    logic zero_fast;
    logic last_iter;

    // A start is only looked at when the divider is not mid-operation.
    assign accept    = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last_iter = (state == RUN) && (count == CNT_W'(WIDTH - 1));

`ifdef SEQ_DIV_ZERO_FAST_EN
    assign zero_fast = accept && (bus.divisor == '0);
`else
    assign zero_fast = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = zero_fast ? DONE : RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                if (accept) state_next = zero_fast ? DONE : RUN;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One restoring iteration: shift in the next dividend bit, trial-subtract.
    // The shifted value carries the guard bit; after a successful subtract the
    // difference is below the divisor, so WIDTH bits hold the new remainder.
    always_comb begin
        r_shift = {r_work, q_work[WIDTH-1]};
        r_next  = r_shift[WIDTH-1:0];
        q_next  = {q_work[WIDTH-2:0], 1'b0};
        if (r_shift >= {1'b0, divisor_q}) begin
            r_next = r_shift[WIDTH-1:0] - divisor_q;
            q_next = {q_work[WIDTH-2:0], 1'b1};
        end
    end

    // Iteration counter: restarts on every accepted start, steps during RUN.
    always_ff @(posedge clk) begin
        if (!rst_n)             count <= '0;
        else if (accept)        count <= '0;
        else if (state == RUN)  count <= count + 1'b1;
    end

    // Working datapath: load operands on accept, iterate during RUN.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; these are always loaded on accept before use,
        // and only the result registers below are architecturally visible.
        if (accept) begin
            r_work    <= '0;
            q_work    <= bus.dividend;
            divisor_q <= bus.divisor;
        end else if (state == RUN) begin
            r_work <= r_next;
            q_work <= q_next;
        end
    end

    // Result registers: change only on entry to DONE (or reset), so they stay
    // stable throughout RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (last_iter) begin
            bus.quotient    <= q_next;
            bus.remainder   <= r_next;
            bus.div_by_zero <= (divisor_q == '0);
        end else if (zero_fast) begin
            bus.quotient    <= '1;
            bus.remainder   <= bus.dividend;
            bus.div_by_zero <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider.
// An 8-bit instance covers latency, boundary values, start-during-RUN,
// back-to-back starts and mid-RUN reset; a 2-bit instance is swept over all
// operand pairs. Outputs are sampled on the falling clock edge.
module tb_seq_divider;
`ifdef SEQ_DIV_ZERO_FAST_EN
    localparam int ZLAT8  = 1;
    localparam int ZBUSY8 = 0;
    localparam int ZLAT2  = 1;
`else
    localparam int ZLAT8  = 9;
    localparam int ZBUSY8 = 8;
    localparam int ZLAT2  = 3;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(8)) a8 ();
    seq_divider_if #(.WIDTH(2)) a2 ();

    seq_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(a8));
    seq_divider #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(a2));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b);
        a8.start    = 1'b1;
        a8.dividend = a;
        a8.divisor  = b;
    endtask

    // Counts falling edges until done; lat = -1 if the budget expires.
    task automatic wait8(output int lat, output int nbusy);
        lat   = -1;
        nbusy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            a8.start = 1'b0;
            if (a8.busy) nbusy++;
            if (a8.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic check8(input string tag, input int q, input int r, input int z);
        check({tag, " quotient"},    a8.quotient,    q);
        check({tag, " remainder"},   a8.remainder,   r);
        check({tag, " div_by_zero"}, a8.div_by_zero, z);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nbusy;
        int done_seen;
        int vec [4][4];
        vec = '{'{255, 255, 1, 0}, '{5, 9, 0, 5}, '{255, 1, 255, 0}, '{0, 3, 0, 0}};

        a8.start = 1'b0; a8.dividend = '0; a8.divisor = '0;
        a2.start = 1'b0; a2.dividend = '0; a2.divisor = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", a8.busy, 0);
        check("reset done", a8.done, 0);
        check8("reset", 0, 0, 0);
        rst_n = 1'b1;

        // 200/7: latency, busy length, result, done is a single pulse
        @(negedge clk);
        drive8(8'd200, 8'd7);
        wait8(lat, nbusy);
        check("200/7 latency", lat, 9);
        check("200/7 busy cycles", nbusy, 8);
        check8("200/7", 28, 4, 0);
        @(negedge clk);
        check("200/7 done pulse width", a8.done, 0);
        check("200/7 quotient held", a8.quotient, 28);

        // Boundary operand pairs
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive8(8'(vec[i][0]), 8'(vec[i][1]));
            wait8(lat, nbusy);
            check($sformatf("%0d/%0d latency", vec[i][0], vec[i][1]), lat, 9);
            check8($sformatf("%0d/%0d", vec[i][0], vec[i][1]), vec[i][2], vec[i][3], 0);
        end

        // Divide by zero
        @(negedge clk);
        drive8(8'd100, 8'd0);
        wait8(lat, nbusy);
        check("100/0 latency", lat, ZLAT8);
        check("100/0 busy cycles", nbusy, ZBUSY8);
        check8("100/0", 255, 100, 1);

        // Start during RUN is ignored; results do not move during RUN
        @(negedge clk);
        drive8(8'd200, 8'd7);
        @(negedge clk);
        a8.start = 1'b0;
        repeat (2) @(negedge clk);
        check("ignore busy in RUN", a8.busy, 1);
        check("ignore quotient stable in RUN", a8.quotient, 255);
        check("ignore remainder stable in RUN", a8.remainder, 100);
        drive8(8'd9, 8'd3);
        wait8(lat, nbusy);
        check("ignore remaining latency", lat, 6);
        check8("ignore 200/7", 28, 4, 0);

        // Back-to-back: start in the DONE cycle
        drive8(8'd9, 8'd3);
        wait8(lat, nbusy);
        check("b2b latency", lat, 9);
        check("b2b busy cycles", nbusy, 8);
        check8("b2b 9/3", 3, 0, 0);

        // Reset in the middle of RUN
        @(negedge clk);
        drive8(8'd200, 8'd7);
        @(negedge clk);
        a8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrun reset busy", a8.busy, 0);
        check("midrun reset done", a8.done, 0);
        check8("midrun reset", 0, 0, 0);
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (a8.done) done_seen++;
        end
        check("midrun reset no done", done_seen, 0);
        @(negedge clk);
        drive8(8'd100, 8'd7);
        wait8(lat, nbusy);
        check("after reset latency", lat, 9);
        check8("after reset 100/7", 14, 2, 0);

        // WIDTH=2 exhaustive sweep
        for (int a = 0; a < 4; a++) begin
            for (int d = 0; d < 4; d++) begin
                int q;
                int r;
                @(negedge clk);
                a2.start    = 1'b1;
                a2.dividend = 2'(a);
                a2.divisor  = 2'(d);
                lat = -1;
                for (int i = 1; i <= 20; i++) begin
                    @(negedge clk);
                    a2.start = 1'b0;
                    if (a2.done) begin
                        lat = i;
                        break;
                    end
                end
                q = int'(a2.quotient);
                r = int'(a2.remainder);
                if (d != 0) begin
                    check($sformatf("w2 %0d/%0d latency", a, d), lat, 3);
                    check($sformatf("w2 %0d/%0d q*d+r", a, d), q * d + r, a);
                    check($sformatf("w2 %0d/%0d r<d", a, d), (r < d) ? 1 : 0, 1);
                    check($sformatf("w2 %0d/%0d quotient", a, d), q, a / d);
                    check($sformatf("w2 %0d/%0d div_by_zero", a, d), a2.div_by_zero, 0);
                end else begin
                    check($sformatf("w2 %0d/0 latency", a), lat, ZLAT2);
                    check($sformatf("w2 %0d/0 quotient", a), q, 3);
                    check($sformatf("w2 %0d/0 remainder", a), r, a);
                    check($sformatf("w2 %0d/0 div_by_zero", a), a2.div_by_zero, 1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
